// File: rtl/ctrl_seq.sv
// Purpose : rotation-run sequencer; a rising edge on s_p_flag_in starts a run
//           LOAD (mux_flag) -> ROT 1..ROT_LAST -> DONE (demux_flag) -> IDLE.
// Latency : start sampled at edge k -> mux_flag after k, demux_flag after k+ROT_LAST+1.
// Ports   : clk, rst_n (async active-low), s_p_flag_in (start request level),
//           mux_flag / rotation[2:0] / demux_flag (all registered, Moore).
// Options : CTRL_RETRIGGER_EN -- a start seen in ROT or DONE restarts the run;
//           undefined, starts outside IDLE are ignored.
module ctrl_seq #(
  parameter int unsigned ROT_LAST = 7   // legal 1..7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_p_flag_in,
  output logic       mux_flag,
  output logic [2:0] rotation,
  output logic       demux_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ROT  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [2:0] LAST = 3'(ROT_LAST);

  state_t     state;
  state_t     state_nx;
  logic       sp_d;
  logic       start;
  logic       mux_nx;
  logic       demux_nx;
  logic [2:0] rot_nx;

  // sp_d samples every cycle regardless of state, so a level held high
  // across a whole run can never produce a second start.
  assign start = s_p_flag_in & ~sp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sp_d       <= 1'b0;
      mux_flag   <= 1'b0;
      rotation   <= 3'd0;
      demux_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      sp_d       <= s_p_flag_in;
      mux_flag   <= mux_nx;
      rotation   <= rot_nx;
      demux_flag <= demux_nx;
    end
  end

  // Outputs are decoded from the next state and registered, so nothing
  // on the output side is combinationally reachable from s_p_flag_in.
  always_comb begin
    state_nx = IDLE;
    rot_nx   = 3'd0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        state_nx = ROT;
        rot_nx   = 3'd1;
      end
      ROT: begin
        // >= rather than == keeps rotation bounded even from a corrupted count
        if (rotation >= LAST) begin
          state_nx = DONE;
          rot_nx   = LAST;
        end else begin
          state_nx = ROT;
          rot_nx   = rotation + 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

`ifdef CTRL_RETRIGGER_EN
    // DONE's demux_flag has already been registered for this cycle, so a
    // restart from DONE still lets the finished result out.
    if (start && (state == ROT || state == DONE)) begin
      state_nx = LOAD;
      rot_nx   = 3'd0;
    end
`endif

    mux_nx   = (state_nx == LOAD);
    demux_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;

`ifdef CTRL_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sp7 = 1'b0;
  logic       sp1 = 1'b0;
  logic       mux7, demux7, mux1, demux1;
  logic [2:0] rot7, rot1;

  ctrl_seq u7 (
    .clk(clk), .rst_n(rst_n), .s_p_flag_in(sp7),
    .mux_flag(mux7), .rotation(rot7), .demux_flag(demux7)
  );

  ctrl_seq #(.ROT_LAST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_p_flag_in(sp1),
    .mux_flag(mux1), .rotation(rot1), .demux_flag(demux1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int checks = 0;

  // Reference model: position within a run, -1 = idle, 0 = load cycle,
  // 1..last = rotation cycles, last+1 = done cycle.
  int p7 = -1, p1 = -1;
  bit prev7 = 1'b0, prev1 = 1'b0;

  function automatic int nxt(int p, bit start, int last);
    if (p < 0) return start ? 0 : -1;
    if (RETRIG && start && p >= 1) return 0;
    if (p >= last + 1) return -1;
    return p + 1;
  endfunction

  // Expected {mux_flag, rotation[2:0], demux_flag} for a run position.
  function automatic logic [4:0] exp_out(int p, int last);
    if (p < 0) return 5'b0;
    if (p == 0) return 5'b1_000_0;
    if (p <= last) return {1'b0, 3'(p), 1'b0};
    return {1'b0, 3'(last), 1'b1};
  endfunction

  // Advance one clock; the model sees the same input values the DUT samples.
  task automatic tick();
    bit s7, s1;
    @(posedge clk);
    if (!rst_n) begin
      p7 = -1; p1 = -1; prev7 = 1'b0; prev1 = 1'b0;
    end else begin
      s7 = sp7 & ~prev7; prev7 = sp7; p7 = nxt(p7, s7, 7);
      s1 = sp1 & ~prev1; prev1 = sp1; p1 = nxt(p1, s1, 1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sp7 = 1'b0; sp1 = 1'b0;
    #3;
    checks++;
    if ({mux7, rot7, demux7} !== 5'b0) $display("FAIL reset_u7: got %b want 00000", {mux7, rot7, demux7});
    else passed++;
    checks++;
    if ({mux1, rot1, demux1} !== 5'b0) $display("FAIL reset_u1: got %b want 00000", {mux1, rot1, demux1});
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({mux7, rot7, demux7} !== exp_out(p7, 7))
        $display("FAIL reset_idle cyc %0d: got %b want %b", i, {mux7, rot7, demux7}, exp_out(p7, 7));
      else passed++;
    end
  endtask

  task automatic test_single_run();
    int nmux = 0, ndemux = 0;
    sp7 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      sp7 = 1'b0;
      nmux += int'(mux7); ndemux += int'(demux7);
      checks++;
      if ({mux7, rot7, demux7} !== exp_out(p7, 7))
        $display("FAIL single_run cyc %0d: got %b want %b", i, {mux7, rot7, demux7}, exp_out(p7, 7));
      else passed++;
    end
    checks++;
    if (nmux != 1 || ndemux != 1) $display("FAIL single_run_pulses: got mux %0d demux %0d want 1 1", nmux, ndemux);
    else passed++;
  endtask

  task automatic test_level_hold();
    int nmux = 0, ndemux = 0;
    sp7 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      nmux += int'(mux7); ndemux += int'(demux7);
      checks++;
      if ({mux7, rot7, demux7} !== exp_out(p7, 7))
        $display("FAIL level_hold cyc %0d: got %b want %b", i, {mux7, rot7, demux7}, exp_out(p7, 7));
      else passed++;
    end
    sp7 = 1'b0;
    tick(); tick();
    checks++;
    if (nmux != 1 || ndemux != 1) $display("FAIL level_hold_pulses: got mux %0d demux %0d want 1 1", nmux, ndemux);
    else passed++;
  endtask

  task automatic test_toggle();
    int ndemux = 0, exp_demux = 0, maxrot = 0, exp_maxrot = 0;
    logic [4:0] e;
    for (int i = 0; i < 40; i++) begin
      sp7 = (i % 2 == 1);
      tick();
      e = exp_out(p7, 7);
      ndemux += int'(demux7); exp_demux += int'(e[0]);
      if (int'(rot7) > maxrot) maxrot = int'(rot7);
      if (int'(e[3:1]) > exp_maxrot) exp_maxrot = int'(e[3:1]);
      checks++;
      if ({mux7, rot7, demux7} !== e)
        $display("FAIL toggle cyc %0d: got %b want %b", i, {mux7, rot7, demux7}, e);
      else passed++;
    end
    sp7 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (ndemux != exp_demux || maxrot != exp_maxrot)
      $display("FAIL toggle_summary: got demux %0d maxrot %0d want %0d %0d", ndemux, maxrot, exp_demux, exp_maxrot);
    else passed++;
  endtask

  task automatic test_rot_last1();
    int busy = 0;
    sp1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      sp1 = 1'b0;
      if (mux1 || rot1 != 3'd0 || demux1) busy++;
      checks++;
      if ({mux1, rot1, demux1} !== exp_out(p1, 1))
        $display("FAIL rot_last1 cyc %0d: got %b want %b", i, {mux1, rot1, demux1}, exp_out(p1, 1));
      else passed++;
    end
    checks++;
    if (busy != 3) $display("FAIL rot_last1_len: got %0d cycles want 3", busy);
    else passed++;
  endtask

  task automatic test_mid_run_reset();
    int ndemux = 0, guard = 0;
    sp7 = 1'b1;
    tick();
    sp7 = 1'b0;
    while (p7 != 4 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (rot7 !== 3'd4) $display("FAIL mid_reset_reach: got rotation %0d want 4", rot7);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mux7, rot7, demux7} !== 5'b0) $display("FAIL mid_reset_async: got %b want 00000", {mux7, rot7, demux7});
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      ndemux += int'(demux7);
      checks++;
      if ({mux7, rot7, demux7} !== exp_out(p7, 7))
        $display("FAIL mid_reset_after cyc %0d: got %b want %b", i, {mux7, rot7, demux7}, exp_out(p7, 7));
      else passed++;
    end
    checks++;
    if (ndemux != 0) $display("FAIL mid_reset_demux: got %0d pulses want 0", ndemux);
    else passed++;
  endtask

  task automatic test_release_high();
    rst_n = 1'b0;
    tick(); tick();
    sp7 = 1'b1; sp1 = 1'b1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (mux7 !== 1'b1 || mux1 !== 1'b1) $display("FAIL release_high_start: got mux %b %b want 1 1", mux7, mux1);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({mux7, rot7, demux7, mux1, rot1, demux1} !== {exp_out(p7, 7), exp_out(p1, 1)})
        $display("FAIL release_high cyc %0d: got %b want %b", i,
                 {mux7, rot7, demux7, mux1, rot1, demux1}, {exp_out(p7, 7), exp_out(p1, 1)});
      else passed++;
    end
    sp7 = 1'b0; sp1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sp7 = ($urandom_range(0, 9) < 4);
      sp1 = ($urandom_range(0, 9) < 3);
      tick();
      checks++;
      if ({mux7, rot7, demux7, mux1, rot1, demux1} !== {exp_out(p7, 7), exp_out(p1, 1)})
        $display("FAIL random cyc %0d: got %b want %b", i,
                 {mux7, rot7, demux7, mux1, rot1, demux1}, {exp_out(p7, 7), exp_out(p1, 1)});
      else passed++;
    end
    sp7 = 1'b0; sp1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_level_hold();
    test_toggle();
    test_rot_last1();
    test_mid_run_reset();
    test_release_high();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
